// File: rtl/falafel_pkg.sv
// Shared types and widths for the falafel request scheduler.
// Optional statistics are enabled with FALAFEL_SCHED_STATS_EN.
package falafel_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned SIZE_W      = 16;
    localparam int unsigned MSG_ID_SIZE = 8;

    typedef logic [SIZE_W-1:0] word_t;

    typedef enum logic {
        OP_ALLOC = 1'b0,
        OP_FREE  = 1'b1
    } sched_op_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } sched_state_t;

    typedef struct packed {
        sched_op_t              op;
        logic [DATA_W-1:0]      data;
        logic [MSG_ID_SIZE-1:0] id;
    } sched_req_t;

    function automatic logic [DATA_W-1:0] zext_size(input word_t size);
        return DATA_W'(size);
    endfunction

endpackage

// File: rtl/falafel_sched_select.sv
// Free-first selection with an alloc anti-starvation budget, plus the
// streak value to commit if the selected request is actually issued.
module falafel_sched_select
    import falafel_pkg::*;
#(
    parameter int unsigned FREE_BURST = 4,
    parameter int unsigned STREAK_W   = 8
) (
    input  logic                alloc_empty_i,
    input  logic                free_empty_i,
    input  logic [STREAK_W-1:0] streak_i,
    output logic                req_avail_o,
    output sched_op_t           pick_op_o,
    output logic [STREAK_W-1:0] streak_next_o
);

    logic budget_left;

    always_comb begin
        budget_left   = (streak_i < STREAK_W'(FREE_BURST));
        req_avail_o   = !alloc_empty_i || !free_empty_i;
        pick_op_o     = OP_ALLOC;
        streak_next_o = streak_i;

        if (!free_empty_i && (alloc_empty_i || budget_left)) begin
            pick_op_o = OP_FREE;
        end

        if (pick_op_o == OP_FREE) begin
            // The streak only advances while an alloc is actually waiting.
            if (!alloc_empty_i && budget_left) begin
                streak_next_o = streak_i + STREAK_W'(1);
            end
        end else if (!alloc_empty_i) begin
            streak_next_o = '0;
        end
    end

endmodule

// File: rtl/falafel_req_scheduler.sv
// Pops alloc/free FIFOs and issues one request at a time to the allocator core.
// Define FALAFEL_SCHED_STATS_EN to add handshake and stall counters.
module falafel_req_scheduler
    import falafel_pkg::*;
#(
    parameter int unsigned FREE_BURST = 4,
    parameter int unsigned STREAK_W   = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   alloc_fifo_empty_i,
    output logic                   alloc_fifo_read_o,
    input  word_t                  alloc_fifo_dout_size_i,
    input  logic [MSG_ID_SIZE-1:0] alloc_fifo_dout_id_i,
    input  logic                   free_fifo_empty_i,
    output logic                   free_fifo_read_o,
    input  logic [DATA_W-1:0]      free_fifo_dout_i,
    output logic                   core_req_val_o,
    input  logic                   core_req_rdy_i,
    output sched_op_t              core_req_op_o,
    output logic [DATA_W-1:0]      core_req_data_o,
    output logic [MSG_ID_SIZE-1:0] core_req_id_o,
    input  logic                   core_done_i,
`ifdef FALAFEL_SCHED_STATS_EN
    output logic [31:0]            stat_alloc_cnt_o,
    output logic [31:0]            stat_free_cnt_o,
    output logic [31:0]            stat_stall_cnt_o,
`endif
    output logic                   busy_o
);

    sched_state_t        state_q, state_d;
    sched_req_t          req_q, req_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    logic                req_avail;
    sched_op_t           pick_op;
    logic [STREAK_W-1:0] streak_next;
    logic                alloc_rd, free_rd;
    logic                handshake;

    falafel_sched_select #(
        .FREE_BURST (FREE_BURST),
        .STREAK_W   (STREAK_W)
    ) u_select (
        .alloc_empty_i (alloc_fifo_empty_i),
        .free_empty_i  (free_fifo_empty_i),
        .streak_i      (streak_q),
        .req_avail_o   (req_avail),
        .pick_op_o     (pick_op),
        .streak_next_o (streak_next)
    );

    assign handshake = (state_q == ST_ISSUE) && core_req_rdy_i;

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        streak_d = streak_q;
        alloc_rd = 1'b0;
        free_rd  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_avail) begin
                    state_d  = ST_ISSUE;
                    streak_d = streak_next;
                    if (pick_op == OP_FREE) begin
                        free_rd    = 1'b1;
                        req_d.op   = OP_FREE;
                        req_d.data = free_fifo_dout_i;
                        req_d.id   = '0;
                    end else begin
                        alloc_rd   = 1'b1;
                        req_d.op   = OP_ALLOC;
                        req_d.data = zext_size(alloc_fifo_dout_size_i);
                        req_d.id   = alloc_fifo_dout_id_i;
                    end
                end
            end
            ST_ISSUE: begin
                if (core_req_rdy_i) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (core_done_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pops are gated by reset so nothing is consumed while the latch is being cleared.
    assign alloc_fifo_read_o = alloc_rd && rst_ni;
    assign free_fifo_read_o  = free_rd && rst_ni;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            req_q    <= '0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            streak_q <= streak_d;
        end
    end

    assign core_req_val_o  = (state_q == ST_ISSUE);
    assign core_req_op_o   = req_q.op;
    assign core_req_data_o = req_q.data;
    assign core_req_id_o   = req_q.id;
    assign busy_o          = (state_q != ST_IDLE);

`ifdef FALAFEL_SCHED_STATS_EN
    logic [31:0] alloc_cnt_q, alloc_cnt_d;
    logic [31:0] free_cnt_q, free_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        alloc_cnt_d = alloc_cnt_q;
        free_cnt_d  = free_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (handshake) begin
            if (req_q.op == OP_FREE) begin
                free_cnt_d = free_cnt_q + 32'd1;
            end else begin
                alloc_cnt_d = alloc_cnt_q + 32'd1;
            end
        end
        if ((state_q == ST_ISSUE) && !core_req_rdy_i) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            alloc_cnt_q <= '0;
            free_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            alloc_cnt_q <= alloc_cnt_d;
            free_cnt_q  <= free_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stat_alloc_cnt_o = alloc_cnt_q;
    assign stat_free_cnt_o  = free_cnt_q;
    assign stat_stall_cnt_o = stall_cnt_q;
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_falafel_req_scheduler.sv
// Directed self-checking bench for falafel_req_scheduler with FWFT FIFO models.
module tb_falafel_req_scheduler;
    import falafel_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   alloc_empty, alloc_read;
    word_t                  alloc_size;
    logic [MSG_ID_SIZE-1:0] alloc_id;
    logic                   free_empty, free_read;
    logic [DATA_W-1:0]      free_addr;
    logic                   core_val;
    logic                   core_rdy = 1'b0;
    sched_op_t              core_op;
    logic [DATA_W-1:0]      core_data;
    logic [MSG_ID_SIZE-1:0] core_id;
    logic                   core_done = 1'b0;
    logic                   busy;
`ifdef FALAFEL_SCHED_STATS_EN
    logic [31:0]            st_alloc, st_free, st_stall;
`endif

    int checks = 0;
    int failures = 0;
    int viol = 0;

    logic [15:0] a_size_mem [256];
    logic [7:0]  a_id_mem   [256];
    logic [31:0] f_addr_mem [256];
    int a_head = 0, a_tail = 0, f_head = 0, f_tail = 0;

    always #5 clk = ~clk;

    assign alloc_empty = (a_head == a_tail);
    assign free_empty  = (f_head == f_tail);
    assign alloc_size  = a_size_mem[a_head[7:0]];
    assign alloc_id    = a_id_mem[a_head[7:0]];
    assign free_addr   = f_addr_mem[f_head[7:0]];

    always @(posedge clk) begin
        if (alloc_read) begin
            if (a_head == a_tail) viol = viol + 1;
            else a_head <= a_head + 1;
        end
        if (free_read) begin
            if (f_head == f_tail) viol = viol + 1;
            else f_head <= f_head + 1;
        end
    end

    falafel_req_scheduler #(
        .FREE_BURST (4),
        .STREAK_W   (8)
    ) dut (
        .clk_i                  (clk),
        .rst_ni                 (rst_n),
        .alloc_fifo_empty_i     (alloc_empty),
        .alloc_fifo_read_o      (alloc_read),
        .alloc_fifo_dout_size_i (alloc_size),
        .alloc_fifo_dout_id_i   (alloc_id),
        .free_fifo_empty_i      (free_empty),
        .free_fifo_read_o       (free_read),
        .free_fifo_dout_i       (free_addr),
        .core_req_val_o         (core_val),
        .core_req_rdy_i         (core_rdy),
        .core_req_op_o          (core_op),
        .core_req_data_o        (core_data),
        .core_req_id_o          (core_id),
        .core_done_i            (core_done),
`ifdef FALAFEL_SCHED_STATS_EN
        .stat_alloc_cnt_o       (st_alloc),
        .stat_free_cnt_o        (st_free),
        .stat_stall_cnt_o       (st_stall),
`endif
        .busy_o                 (busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_alloc(input logic [15:0] s, input logic [7:0] id);
        a_size_mem[a_tail[7:0]] = s;
        a_id_mem[a_tail[7:0]]   = id;
        a_tail = a_tail + 1;
    endtask

    task automatic push_free(input logic [31:0] a);
        f_addr_mem[f_tail[7:0]] = a;
        f_tail = f_tail + 1;
    endtask

    task automatic do_reset;
        core_rdy  = 1'b0;
        core_done = 1'b0;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        core_rdy  = 1'b0;
        core_done = 1'b0;
        rst_n     = 1'b0;
        tick();
        tick();
        checks++;
        if ({core_val, busy, alloc_read, free_read} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=0000", {core_val, busy, alloc_read, free_read});
        end
        checks++;
        if ({core_op, core_data, core_id} !== '0) begin
            failures++;
            $display("FAIL reset_req got op=%0d data=%h id=%h want zeros", core_op, core_data, core_id);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_empty busy got=%b want=0", busy);
        end
    endtask

    task automatic test_alloc_only;
        do_reset();
        push_alloc(16'h0040, 8'd3);
        #1;
        checks++;
        if ({alloc_read, free_read, core_val} !== 3'b100) begin
            failures++;
            $display("FAIL alloc_c0 read/free/val got=%b want=100", {alloc_read, free_read, core_val});
        end
        tick();
        checks++;
        if (core_val !== 1'b1 || core_op !== OP_ALLOC || core_data !== 32'h40 || core_id !== 8'd3) begin
            failures++;
            $display("FAIL alloc_c1 got val=%b op=%0d data=%h id=%0d want 1/0/40/3",
                     core_val, core_op, core_data, core_id);
        end
        checks++;
        if (alloc_read !== 1'b0) begin
            failures++;
            $display("FAIL alloc_c1_noread got=%b want=0", alloc_read);
        end
        tick();
        core_rdy = 1'b1;
        tick();
        core_rdy = 1'b0;
        checks++;
        if ({busy, core_val} !== 2'b10) begin
            failures++;
            $display("FAIL alloc_wait busy/val got=%b want=10", {busy, core_val});
        end
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL alloc_done_idle busy got=%b want=0", busy);
        end
        // Largest size must come out zero-extended.
        push_alloc(16'hFFFF, 8'hFF);
        tick();
        checks++;
        if (core_data !== 32'h0000_FFFF || core_id !== 8'hFF) begin
            failures++;
            $display("FAIL alloc_zext got data=%h id=%h want 0000ffff/ff", core_data, core_id);
        end
        core_rdy = 1'b1;
        tick();
        core_rdy  = 1'b0;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
    endtask

    task automatic test_free_first_order;
        int exp_free [20];
        int n, fi, ai;
        logic [31:0] exp_data;
        exp_free = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            push_free(32'h1000 + 32'(i));
            push_alloc(16'h0010 + 16'(i), 8'(i + 1));
        end
        core_rdy  = 1'b1;
        core_done = 1'b1;
        n = 0; fi = 0; ai = 0;
        for (int cyc = 0; cyc < 200 && n < 20; cyc++) begin
            tick();
            if (core_val === 1'b1) begin
                exp_data = exp_free[n] != 0 ? 32'h1000 + 32'(fi) : 32'h10 + 32'(ai);
                checks++;
                if (core_op !== (exp_free[n] != 0 ? OP_FREE : OP_ALLOC)) begin
                    failures++;
                    $display("FAIL order_op[%0d] got=%0d want=%0d", n, core_op, exp_free[n]);
                end
                checks++;
                if (core_data !== exp_data) begin
                    failures++;
                    $display("FAIL order_data[%0d] got=%h want=%h", n, core_data, exp_data);
                end
                if (exp_free[n] != 0) fi++;
                else ai++;
                n++;
            end
        end
        checks++;
        if (n != 20) begin
            failures++;
            $display("FAIL order_count got=%0d want=20", n);
        end
        tick();
        tick();
        core_rdy  = 1'b0;
        core_done = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL order_drained busy got=%b want=0", busy);
        end
`ifdef FALAFEL_SCHED_STATS_EN
        checks++;
        if (st_alloc !== 32'd10 || st_free !== 32'd10) begin
            failures++;
            $display("FAIL stat_counts got alloc=%0d free=%0d want 10/10", st_alloc, st_free);
        end
`endif
    endtask

    task automatic test_streak_no_alloc;
        int exp_free [12];
        int n;
        bit pushed;
        exp_free = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
        do_reset();
        for (int i = 0; i < 6; i++) push_free(32'h2000 + 32'(i));
        core_rdy  = 1'b1;
        core_done = 1'b1;
        n = 0;
        pushed = 1'b0;
        for (int cyc = 0; cyc < 200 && n < 12; cyc++) begin
            tick();
            if (core_val === 1'b1) begin
                checks++;
                if (core_op !== (exp_free[n] != 0 ? OP_FREE : OP_ALLOC)) begin
                    failures++;
                    $display("FAIL streak_op[%0d] got=%0d want=%0d", n, core_op, exp_free[n]);
                end
                n++;
            end
            if (!pushed && f_tail == f_head && n == 6) begin
                for (int i = 6; i < 11; i++) push_free(32'h2000 + 32'(i));
                push_alloc(16'h0077, 8'd9);
                pushed = 1'b1;
            end
        end
        checks++;
        if (n != 12) begin
            failures++;
            $display("FAIL streak_count got=%0d want=12", n);
        end
        tick();
        tick();
        core_rdy  = 1'b0;
        core_done = 1'b0;
        tick();
    endtask

    task automatic test_backpressure;
        do_reset();
        push_free(32'h0000_ABCD);
        tick();
        push_alloc(16'h0005, 8'd7);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (core_val !== 1'b1 || core_op !== OP_FREE || core_data !== 32'hABCD
                || alloc_read !== 1'b0 || free_read !== 1'b0) begin
                failures++;
                $display("FAIL stall[%0d] got val=%b op=%0d data=%h rd=%b%b want 1/1/abcd/00",
                         i, core_val, core_op, core_data, alloc_read, free_read);
            end
            tick();
        end
`ifdef FALAFEL_SCHED_STATS_EN
        checks++;
        if (st_stall !== 32'd5) begin
            failures++;
            $display("FAIL stall_cnt got=%0d want=5", st_stall);
        end
`endif
        core_rdy = 1'b1;
        tick();
        core_rdy  = 1'b0;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        checks++;
        if (core_val !== 1'b1 || core_op !== OP_ALLOC || core_id !== 8'd7) begin
            failures++;
            $display("FAIL stall_next got val=%b op=%0d id=%0d want 1/0/7", core_val, core_op, core_id);
        end
        core_rdy = 1'b1;
        tick();
        core_rdy  = 1'b0;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
    endtask

    task automatic test_spurious_done;
        do_reset();
        core_done = 1'b1;
        tick();
        checks++;
        if ({busy, core_val} !== 2'b00) begin
            failures++;
            $display("FAIL spur_idle busy/val got=%b want=00", {busy, core_val});
        end
        core_done = 1'b0;
        push_alloc(16'h0031, 8'd4);
        tick();
        core_done = 1'b1;
        tick();
        checks++;
        if (core_val !== 1'b1 || core_id !== 8'd4) begin
            failures++;
            $display("FAIL spur_issue got val=%b id=%0d want 1/4", core_val, core_id);
        end
        core_done = 1'b0;
        core_rdy  = 1'b1;
        tick();
        core_rdy = 1'b0;
        tick();
        checks++;
        if ({busy, core_val} !== 2'b10) begin
            failures++;
            $display("FAIL spur_wait busy/val got=%b want=10", {busy, core_val});
        end
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL spur_done busy got=%b want=0", busy);
        end
    endtask

    task automatic test_reset_in_wait;
        do_reset();
        push_alloc(16'h0021, 8'd5);
        push_alloc(16'h0022, 8'd6);
        tick();
        core_rdy = 1'b1;
        tick();
        core_rdy = 1'b0;
        rst_n    = 1'b0;
        tick();
        checks++;
        if ({core_val, busy, alloc_read, free_read, core_op, core_data, core_id} !== '0) begin
            failures++;
            $display("FAIL rst_wait_outs got val=%b busy=%b rd=%b%b op=%0d data=%h id=%h want zeros",
                     core_val, busy, alloc_read, free_read, core_op, core_data, core_id);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (alloc_read !== 1'b1) begin
            failures++;
            $display("FAIL rst_wait_reread got=%b want=1", alloc_read);
        end
        tick();
        checks++;
        if (core_val !== 1'b1 || core_id !== 8'd6 || core_data !== 32'h22) begin
            failures++;
            $display("FAIL rst_wait_head got val=%b id=%0d data=%h want 1/6/22", core_val, core_id, core_data);
        end
        core_rdy = 1'b1;
        tick();
        core_rdy  = 1'b0;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
    endtask

    task automatic test_fifo_protocol;
        checks++;
        if (viol !== 0) begin
            failures++;
            $display("FAIL read_while_empty got=%0d want=0", viol);
        end
        checks++;
        if (a_head != a_tail || f_head != f_tail) begin
            failures++;
            $display("FAIL fifo_drained got a=%0d/%0d f=%0d/%0d want equal", a_head, a_tail, f_head, f_tail);
        end
    endtask

    initial begin
        test_reset();
        test_alloc_only();
        test_free_first_order();
        test_streak_no_alloc();
        test_backpressure();
        test_spurious_done();
        test_reset_in_wait();
        test_fifo_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/falafel_req_scheduler.md
Name: falafel_req_scheduler

Overview:
Sequences the allocator core. Pops requests from the alloc FIFO and the free FIFO, picks one per operation under a free-first policy with an anti-starvation budget for allocs, and issues it to the single-outstanding allocator core. Sits between the input arbiter's FIFOs and the allocator core.

Parameters:
FREE_BURST, 4, max consecutive frees issued while an alloc is pending; range 1..255.
STREAK_W, 8, width of the free-streak counter; must hold FREE_BURST.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; one clock; reset is synchronous and active-low
alloc_fifo_empty_i  in  1  alloc FIFO empty
alloc_fifo_read_o  out  1  pop alloc FIFO, first-word-fall-through
alloc_fifo_dout_size_i  in  word_t  head alloc size
alloc_fifo_dout_id_i  in  MSG_ID_SIZE  head alloc id
free_fifo_empty_i  in  1  free FIFO empty
free_fifo_read_o  out  1  pop free FIFO
free_fifo_dout_i  in  DATA_W  head free address
core_req_val_o  out  1  request valid to core
core_req_rdy_i  in  1  core accepts request
core_req_op_o  out  sched_op_t  OP_ALLOC / OP_FREE
core_req_data_o  out  DATA_W  size (zero-extended) or free address
core_req_id_o  out  MSG_ID_SIZE  alloc id; 0 for free
core_done_i  in  1  core finished the accepted op (1-cycle pulse)
busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, all outputs 0, streak 0, request register 0. Reset mid-operation aborts; no FIFO pop is replayed or lost beyond the one already latched.
- FSM IDLE -> ISSUE -> WAIT_DONE -> IDLE.
- IDLE: if any FIFO non-empty, select, assert exactly one read_o for one cycle, latch head into request register and op, go to ISSUE. Both empty: stay.
- Selection: only one non-empty -> that one. Both non-empty: free if streak < FREE_BURST, else alloc.
- Streak: free issue -> streak+1, saturating at FREE_BURST; alloc issue -> 0. Free issued while alloc FIFO empty leaves streak unchanged.
- ISSUE: core_req_val_o=1 and data/op/id stable until core_req_rdy_i; on handshake go to WAIT_DONE. val never drops before rdy.
- WAIT_DONE: wait for core_done_i, then IDLE. core_done_i is ignored in IDLE and ISSUE. The core never asserts done in the handshake cycle.
- Latency: non-empty FIFO in IDLE at cycle 0 -> core_req_val_o high at cycle 1. Done at cycle N -> next read_o no earlier than N+1.
- Data width: alloc size zero-extended to DATA_W. FIFO full/empty flags are never violated: read_o is only asserted with the matching empty_i=0.
- read_o is combinational from state and empty flags, never asserted outside IDLE.

Optional Feature:
FALAFEL_SCHED_STATS_EN: when defined, adds outputs stat_alloc_cnt_o, stat_free_cnt_o (32b, count handshakes) and stat_stall_cnt_o (32b, cycles in ISSUE with rdy=0). All cleared on reset, wrap at 2^32. When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- falafel_pkg: sched_op_t enum (OP_ALLOC=0, OP_FREE=1), sched_state_t, sched_req_t struct {op, data, id}.
- Sub-module falafel_sched_select: combinational select and streak-update logic, for isolated unit test. The FSM stays in the top.

Test Plan:
- Alloc only: push size 0x40 id 3 -> read pulse at c0, core_req at c1 with op=ALLOC, data=0x40, id=3; rdy at c3 -> WAIT_DONE; done -> IDLE; busy_o low after.
- Both FIFOs hold 10 entries, FREE_BURST=4, core instant rdy/done -> issue order F,F,F,F,A,F,F,F,F,A...
- Free only, 6 entries, then alloc arrives -> streak is 0 (saturation not reached while alloc absent); next 4 frees precede the alloc.
- Backpressure: rdy low for 5 cycles -> val, op, data stable for all 5; no read_o; stall count =5 with FALAFEL_SCHED_STATS_EN.
- Spurious done in IDLE/ISSUE -> ignored, no state change.
- rst_ni low during WAIT_DONE -> next cycle all outputs 0, state IDLE; with non-empty FIFO, re-issues from FIFO head.
